// File: rtl/mcp_sync_pkg.sv
// Shared limits and helpers for the multi-bit MCP bank synchronizer.
package mcp_sync_pkg;

  localparam int unsigned MIN_DATA_WIDTH  = 1;
  localparam int unsigned MAX_DATA_WIDTH  = 1024;
  localparam int unsigned MIN_DEPTH       = 2;
  localparam int unsigned MAX_DEPTH       = 16;
  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 4;

  // Width needed to count 0..depth held slots.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mcp_sync_vec.sv
// Per-bit flop-chain synchronizer for a vector of independent toggle flags.
module mcp_sync_vec #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/multibit_mcp_bank_sync.sv
// Slot-bank CDC FIFO: data lives in A-domain registers, only per-slot toggle
// flags cross; B reads the slot mux directly once its flag has arrived.
module multibit_mcp_bank_sync
  import mcp_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    avalid,
  input  logic [DATA_WIDTH-1:0]   adata,
  output logic                    aready,
  output logic [$clog2(DEPTH):0]  alevel,
  input  logic                    bclk,
  input  logic                    breset,
  output logic                    bvalid,
  output logic [DATA_WIDTH-1:0]   bdata,
  input  logic                    bready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be in 1..1024");
  end

  logic [DATA_WIDTH-1:0] slot [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DEPTH-1:0]      aflag;
  logic [DEPTH-1:0]      aflag_nxt;
  logic [DEPTH-1:0]      aflag_sync;
  logic [DEPTH-1:0]      bflag;
  logic [DEPTH-1:0]      bflag_nxt;
  logic [DEPTH-1:0]      bflag_sync;
  logic [DEPTH-1:0]      held;
  logic [LVL_W-1:0]      level_nxt;
  logic                  a_xfer;
  logic                  b_xfer;

  // A side: a slot is free when its flag matches the returned B flag.
  assign aready = (aflag[wptr] == bflag_sync[wptr]);
  assign a_xfer = avalid && aready;

  always_comb begin
    aflag_nxt = aflag;
    if (a_xfer) aflag_nxt[wptr] = ~aflag[wptr];
  end

  // Level counts new writes immediately; frees appear once the B flag returns.
  assign held = aflag_nxt ^ bflag_sync;

  always_comb begin
    level_nxt = '0;
    for (int i = 0; i < DEPTH; i++) level_nxt = level_nxt + LVL_W'(held[i]);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr   <= '0;
      aflag  <= '0;
      alevel <= '0;
    end else begin
      if (a_xfer) wptr <= wptr + PTR_W'(1);
      aflag  <= aflag_nxt;
      alevel <= level_nxt;
    end
  end

  // Slot payload is deliberately unreset; it is only observed behind a valid flag.
  always_ff @(posedge aclk) begin
    if (a_xfer) slot[wptr] <= adata;
  end

  // B side: a slot holds a word when the arrived A flag differs from ours.
  assign bvalid = (aflag_sync[rptr] != bflag[rptr]);
  assign bdata  = slot[rptr];
  assign b_xfer = bvalid && bready;

  always_comb begin
    bflag_nxt = bflag;
    if (b_xfer) bflag_nxt[rptr] = ~bflag[rptr];
  end

  always_ff @(posedge bclk) begin
    if (breset) begin
      rptr  <= '0;
      bflag <= '0;
    end else begin
      if (b_xfer) rptr <= rptr + PTR_W'(1);
      bflag <= bflag_nxt;
    end
  end

  mcp_sync_vec #(.WIDTH(DEPTH), .STAGES(SYNC_STAGES)) u_a2b (
    .clk   (bclk),
    .reset (breset),
    .d     (aflag),
    .q     (aflag_sync)
  );

  mcp_sync_vec #(.WIDTH(DEPTH), .STAGES(SYNC_STAGES)) u_b2a (
    .clk   (aclk),
    .reset (areset),
    .d     (bflag),
    .q     (bflag_sync)
  );

endmodule

// File: doc/multibit_mcp_bank_sync.md
MULTIBIT_MCP_BANK_SYNC -- requirements
Module: multibit_mcp_bank_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH, default 4, number of slots; power of two, 2..16.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per crossing (2..4).
REQ-004 aclk  input  1  source clock; areset  input  1  reset, synchronous to aclk, active-high.
REQ-005 bclk  input  1  destination clock; breset  input  1  reset, synchronous to bclk, active-high.
REQ-006 avalid  input  1  source word offered; adata  input  DATA_WIDTH  source word.
REQ-007 aready  output  1  free slot available at write pointer.
REQ-008 alevel  output  $clog2(DEPTH)+1  slots currently held from A's view (written, ack not yet seen).
REQ-009 bvalid  output  1  word available; bdata  output  DATA_WIDTH  word at read pointer.
REQ-010 bready  input  1  destination accepts word.

Function
REQ-011 Transfer on A SHALL occur when avalid && aready at aclk edge; on B when bvalid && bready at bclk edge.
REQ-012 Storage: DEPTH x DATA_WIDTH slot registers in aclk domain, written only on A transfer at slot wptr.
REQ-013 A domain SHALL keep toggle vector aflag[DEPTH]; A transfer toggles aflag[wptr] and advances wptr mod DEPTH.
REQ-014 B domain SHALL keep toggle vector bflag[DEPTH]; B transfer toggles bflag[rptr] and advances rptr mod DEPTH.
REQ-015 aflag SHALL cross to bclk and bflag to aclk, each bit through SYNC_STAGES flops; no other signal crosses except slot data.
REQ-016 Slot data SHALL be read in B without synchronization (MCP); slot contents stable whenever B may sample them.
REQ-017 aready = (aflag[wptr] == bflag_sync[wptr]); combinational from registers only, no avalid dependence.
REQ-018 bvalid = (aflag_sync[rptr] != bflag[rptr]); bdata = slot[rptr], combinational mux, stable while bvalid && !bready.
REQ-019 Forward latency: word written at aclk edge visible as bvalid after SYNC_STAGES to SYNC_STAGES+1 bclk edges.
REQ-020 Return latency: slot freed (aready/alevel) SYNC_STAGES to SYNC_STAGES+1 aclk edges after B transfer.
REQ-021 alevel = popcount(aflag ^ bflag_sync), registered; range 0..DEPTH.
REQ-022 Full: alevel == DEPTH -> aready = 0; avalid held with no effect, no overwrite.
REQ-023 Empty: bvalid = 0; bready ignored, rptr/bflag unchanged.
REQ-024 Pointer wrap DEPTH-1 -> 0 SHALL be seamless; order preserved strictly FIFO, no loss or duplication.
REQ-025 Simultaneous A and B transfers on different slots SHALL both complete in the same respective edges.
REQ-026 With equal clocks, sustained throughput SHALL be 1 word/cycle when DEPTH >= 2*SYNC_STAGES+2.

Reset
REQ-027 areset: wptr=0, aflag=0, bflag_sync=0, alevel=0, aready=1 after edge; slot data not reset.
REQ-028 breset: rptr=0, bflag=0, aflag_sync=0, bvalid=0; bdata value undefined while bvalid=0.
REQ-029 Both resets SHALL be asserted overlapping for >= SYNC_STAGES+1 cycles of slower clock; single-side reset mid-operation is unsupported, integrator enforces.
REQ-030 Reset mid-transfer (both asserted) SHALL discard all held words; first post-reset word is first delivered.

Structure
REQ-031 Package mcp_sync_pkg SHALL hold parameter limits (MAX_DEPTH, MIN/MAX_SYNC_STAGES) and a level-width function.
REQ-032 Sub-module mcp_sync_vec (WIDTH, STAGES; clk, reset, d, q) SHALL implement the per-bit synchronizer, used twice.
REQ-033 Elaboration assertions SHALL reject non-power-of-two DEPTH and out-of-range SYNC_STAGES.

Verification (DATA_WIDTH=32, DEPTH=4, SYNC_STAGES=2)
REQ-034 Single word: write 0xDEADBEEF, bready=1 -> bdata=0xDEADBEEF with bvalid within 3 bclk edges; alevel 1 then 0.
REQ-035 Fill: bready=0, write 0x1..0x5 -> aready=0 after 4th, alevel=4, 0x5 held; release bready -> 1,2,3,4,5 in order.
REQ-036 Wrap: 12 words 0x10..0x1B, aclk 100 MHz, bclk 37 MHz, random bready -> exact in-order sequence, no duplicates.
REQ-037 Equal clocks, DEPTH=8, avalid=bready=1 for 100 cycles -> 100 - startup words, >= 1 word/cycle in steady state.
REQ-038 Reset: both resets asserted with alevel=3 -> after release alevel=0, bvalid=0, next written 0xA5 is first delivered.
REQ-039 Stability: bvalid=1, bready=0 for 20 bclk -> bdata constant; concurrent A writes do not alter it.
